text_writer: RTL and testbench
==============================

Name: text_writer

Overview:
- Writer side of the text-mode video path: takes a byte stream of characters and control codes and writes glyph codes into the character buffer, which the video block reads.
- Tracks a cursor and handles CR, LF, BS and form-feed, wrap-around and hardware scroll.
- Sits on its own write port of the dual-port memory (the port the video block does not use). It feeds console output from the core, or from a debug UART, into the screen.

Parameters:
- P_addr_bits, 16, memory address width.
- P_base, 16'h6000, address of character cell (0,0).
- P_cols, 32, columns per row; must be a power of two.
- P_rows, 32, rows per screen; must be ≥ 2.
- P_blank, 8'h20, fill code used for cleared cells.

Ports:
- I_clock  in  1  system clock; all logic rises on this edge.
- I_reset  in  1  reset, active-low, asynchronous assert, synchronous release.
- I_char_data  in  8  character or control code.
- I_char_valid  in  1  I_char_data is valid.
- O_char_ready  out  1  block accepts a character this cycle.
- O_mem_addr  out  P_addr_bits  memory address.
- O_mem_rden  out  1  memory read enable.
- O_mem_wren  out  1  memory write enable.
- O_mem_data  out  8  memory write data.
- I_mem_data  in  8  memory read data; valid one cycle after the rden cycle.
- O_busy  out  1  scroll or clear in progress.
- O_cursor_col  out  $clog2(P_cols)  current column.
- O_cursor_row  out  $clog2(P_rows)  current row.

Behaviour:
- Reset state:
  - All outputs 0, including O_char_ready.
  - Cursor (0,0), state IDLE. No automatic clear.
  - Assertion mid-operation aborts immediately; buffer contents are left partial.
- Cell address: P_base + row*P_cols + col, formed as a concatenation, so P_cols must be a power of two.
- States: IDLE, PUT, SCROLL_RD, SCROLL_WR, FILL.
- Handshake:
  - O_char_ready=1 only in IDLE.
  - A transfer occurs on a rising edge with valid & ready.
  - I_char_data is sampled on that edge.
- Printable characters (0x20..0x7E):
  - IDLE → PUT. In PUT, O_mem_wren=1, address = cursor cell, data = character. One cycle.
  - Then col+1.
  - If col was P_cols-1: col=0 and row+1.
  - If row was P_rows-1: enter SCROLL_RD and keep row at P_rows-1; otherwise return to IDLE.
  - Throughput: 1 character per 2 cycles without scroll.
- 0x0D (CR): col=0; stay IDLE, next character accepted on the following cycle.
- 0x0A (LF): row+1; if row was P_rows-1, enter SCROLL_RD; col unchanged.
- 0x08 (BS): col-1 if col>0, else no change; the cell is not erased.
- 0x0C (FF): cursor (0,0), enter FILL over all P_rows*P_cols cells.
- All other codes are accepted and discarded.
- Scroll, for i = 0 .. (P_rows-1)*P_cols-1:
  - SCROLL_RD: rden=1, addr = P_base+P_cols+i.
  - SCROLL_WR: wren=1, addr = P_base+i, O_mem_data = I_mem_data.
  - Then FILL over the last row only.
- FILL: one cell per cycle, wren=1, data = P_blank.
- Timing for 32x32: a scroll takes 2*992 + 32 = 2016 cycles; a clear takes 1024 cycles. Return to IDLE follows.
- O_busy=1 in SCROLL_RD, SCROLL_WR and FILL.
- rden and wren are never both high in the same cycle.
- Address and enable outputs are registered, except O_mem_data in SCROLL_WR, which passes I_mem_data straight through.
- I_char_valid held while busy: the character stays pending and is taken on the first IDLE cycle.

Optional Feature:
- Macro: TEXT_WRITER_TAB_EN.
- Defined: 0x09 moves col to the next multiple of 8. If that reaches or exceeds P_cols, it behaves as wrap (col=0, row+1, scroll if on the last row). No cells are written.
- Undefined: 0x09 is discarded like any other unsupported code.

Decomposition:
- Package text_writer_pkg holds:
  - the state enum;
  - control-code constants CHR_BS, CHR_TAB, CHR_LF, CHR_FF, CHR_CR;
  - the printable range bounds.
- One natural sub-module, text_writer_cursor: holds col/row, applies advance, newline, BS, tab and home, and flags the scroll request. The main module keeps the FSM and memory sequencing.

Test Plan:
- After reset, send 'A' (0x41) → one write, addr 16'h6000, data 0x41. Cursor (1,0). Ready low for exactly 1 cycle.
- Send 32 × 'B' on row 5 → last write at 16'h60BF. Cursor (0,6). No scroll.
- Preload memory with cell value = row index. Cursor (0,31), send LF → O_busy for 2016 cycles. Row r holds r+1 for r<31, row 31 holds 0x20, cursor (0,31).
- Send FF → 1024 writes of 0x20 to 16'h6000–16'h63FF. Cursor (0,0). No input accepted while busy.
- Send BS at col 0, then CR at col 17 → cursor unchanged, then col=0. No memory writes.
- Assert I_reset low mid-scroll → all outputs 0 at once, no further writes. After release, cursor (0,0) and ready high. With TEXT_WRITER_TAB_EN, TAB from col 3 → col 8.

Source files
------------

// File: rtl/text_writer_pkg.sv
// Shared types and character constants for the text-mode writer.
package text_writer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    SCROLL_RD,
    SCROLL_WR,
    FILL
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_ADV,
    OP_NL,
    OP_CR,
    OP_BS,
    OP_TAB,
    OP_HOME
  } cursor_op_e;

  localparam logic [7:0] CHR_BS  = 8'h08;
  localparam logic [7:0] CHR_TAB = 8'h09;
  localparam logic [7:0] CHR_LF  = 8'h0A;
  localparam logic [7:0] CHR_FF  = 8'h0C;
  localparam logic [7:0] CHR_CR  = 8'h0D;

  localparam logic [7:0] CHR_PRINT_LO = 8'h20;
  localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CHR_PRINT_LO) && (c <= CHR_PRINT_HI);
  endfunction

endpackage

// File: rtl/text_writer_cursor.sv
// Cursor position register: applies one cursor operation per cycle and
// flags when a newline would run off the bottom row (row is then held).
module text_writer_cursor
  import text_writer_pkg::*;
#(
  parameter int unsigned P_cols = 32,
  parameter int unsigned P_rows = 32
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  cursor_op_e                 op,
  output logic [$clog2(P_cols)-1:0]  col,
  output logic [$clog2(P_rows)-1:0]  row,
  output logic                       scroll_req
);

  localparam int unsigned CW = $clog2(P_cols);
  localparam int unsigned RW = $clog2(P_rows);

  logic [CW-1:0] col_nx;
  logic [RW-1:0] row_nx;
  logic [31:0]   tab_nx;
  logic          newline;
  logic          last_row;

  always_comb begin
    col_nx     = col;
    row_nx     = row;
    newline    = 1'b0;
    scroll_req = 1'b0;
    last_row   = (row == RW'(P_rows - 1));
    tab_nx     = (32'(col) | 32'd7) + 32'd1;
    case (op)
      OP_ADV: begin
        if (col == CW'(P_cols - 1)) begin
          col_nx  = '0;
          newline = 1'b1;
        end else begin
          col_nx = col + CW'(1);
        end
      end
      OP_NL:  newline = 1'b1;
      OP_CR:  col_nx = '0;
      OP_BS:  if (col != '0) col_nx = col - CW'(1);
      OP_TAB: begin
        if (tab_nx >= P_cols) begin
          col_nx  = '0;
          newline = 1'b1;
        end else begin
          col_nx = CW'(tab_nx);
        end
      end
      OP_HOME: begin
        col_nx = '0;
        row_nx = '0;
      end
      default: ;
    endcase
    if (newline) begin
      if (last_row) scroll_req = 1'b1;
      else          row_nx     = row + RW'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nx;
      row <= row_nx;
    end
  end

endmodule

// File: rtl/text_writer.sv
// Character-stream writer into the text-mode buffer: cursor, control codes,
// hardware scroll and clear. Define TEXT_WRITER_TAB_EN to honour 0x09 as tab.
module text_writer
  import text_writer_pkg::*;
#(
  parameter int unsigned            P_addr_bits = 16,
  parameter logic [P_addr_bits-1:0] P_base      = 16'h6000,
  parameter int unsigned            P_cols      = 32,
  parameter int unsigned            P_rows      = 32,
  parameter logic [7:0]             P_blank     = 8'h20
) (
  input  logic                       I_clock,
  input  logic                       I_reset,
  input  logic [7:0]                 I_char_data,
  input  logic                       I_char_valid,
  output logic                       O_char_ready,
  output logic [P_addr_bits-1:0]     O_mem_addr,
  output logic                       O_mem_rden,
  output logic                       O_mem_wren,
  output logic [7:0]                 O_mem_data,
  input  logic [7:0]                 I_mem_data,
  output logic                       O_busy,
  output logic [$clog2(P_cols)-1:0]  O_cursor_col,
  output logic [$clog2(P_rows)-1:0]  O_cursor_row
);

  localparam int unsigned NW = $clog2(P_rows * P_cols);
  localparam logic [NW-1:0] SCROLL_LAST    = NW'((P_rows - 1) * P_cols - 1);
  localparam logic [NW-1:0] LAST_ROW_FIRST = NW'((P_rows - 1) * P_cols);
  localparam logic [NW-1:0] CELL_LAST      = NW'(P_rows * P_cols - 1);

  state_e      state;
  logic [NW-1:0] cnt;
  logic [7:0]  data_q;
  logic        scroll_pend;
  logic        take;
  logic        scroll_req;
  cursor_op_e  op;

  function automatic logic [P_addr_bits-1:0] cell_addr(input logic [NW-1:0] n);
    return P_base + P_addr_bits'(n);
  endfunction

  // Scroll copy data is not registered: the read result feeds the write port directly.
  assign O_mem_data = (state == SCROLL_WR) ? I_mem_data : data_q;

  always_comb begin
    take = I_char_valid && O_char_ready;
    op   = OP_NOP;
    if (take) begin
      if (is_printable(I_char_data)) begin
        op = OP_ADV;
      end else begin
        case (I_char_data)
          CHR_CR:  op = OP_CR;
          CHR_LF:  op = OP_NL;
          CHR_BS:  op = OP_BS;
          CHR_FF:  op = OP_HOME;
`ifdef TEXT_WRITER_TAB_EN
          CHR_TAB: op = OP_TAB;
`endif
          default: op = OP_NOP;
        endcase
      end
    end
  end

  text_writer_cursor #(
    .P_cols(P_cols),
    .P_rows(P_rows)
  ) u_cursor (
    .clock      (I_clock),
    .rst_n      (I_reset),
    .op         (op),
    .col        (O_cursor_col),
    .row        (O_cursor_row),
    .scroll_req (scroll_req)
  );

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      data_q       <= '0;
      scroll_pend  <= 1'b0;
      O_char_ready <= 1'b0;
      O_mem_addr   <= '0;
      O_mem_rden   <= 1'b0;
      O_mem_wren   <= 1'b0;
      O_busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          O_char_ready <= 1'b1;
          if (take) begin
            if (op == OP_ADV) begin
              state        <= PUT;
              O_char_ready <= 1'b0;
              O_mem_wren   <= 1'b1;
              O_mem_addr   <= P_base + P_addr_bits'({O_cursor_row, O_cursor_col});
              data_q       <= I_char_data;
              scroll_pend  <= scroll_req;
            end else if (scroll_req) begin
              state        <= SCROLL_RD;
              O_char_ready <= 1'b0;
              O_busy       <= 1'b1;
              O_mem_rden   <= 1'b1;
              O_mem_addr   <= cell_addr(NW'(P_cols));
              cnt          <= '0;
            end else if (op == OP_HOME) begin
              state        <= FILL;
              O_char_ready <= 1'b0;
              O_busy       <= 1'b1;
              O_mem_wren   <= 1'b1;
              O_mem_addr   <= cell_addr('0);
              data_q       <= P_blank;
              cnt          <= '0;
            end
          end
        end
        PUT: begin
          O_mem_wren  <= 1'b0;
          scroll_pend <= 1'b0;
          if (scroll_pend) begin
            state      <= SCROLL_RD;
            O_busy     <= 1'b1;
            O_mem_rden <= 1'b1;
            O_mem_addr <= cell_addr(NW'(P_cols));
            cnt        <= '0;
          end else begin
            state        <= IDLE;
            O_char_ready <= 1'b1;
          end
        end
        SCROLL_RD: begin
          state      <= SCROLL_WR;
          O_mem_rden <= 1'b0;
          O_mem_wren <= 1'b1;
          O_mem_addr <= cell_addr(cnt);
        end
        SCROLL_WR: begin
          O_mem_wren <= 1'b0;
          if (cnt == SCROLL_LAST) begin
            state      <= FILL;
            O_mem_wren <= 1'b1;
            O_mem_addr <= cell_addr(LAST_ROW_FIRST);
            data_q     <= P_blank;
            cnt        <= LAST_ROW_FIRST;
          end else begin
            state      <= SCROLL_RD;
            O_mem_rden <= 1'b1;
            O_mem_addr <= cell_addr(cnt + NW'(P_cols + 1));
            cnt        <= cnt + NW'(1);
          end
        end
        FILL: begin
          if (cnt == CELL_LAST) begin
            state        <= IDLE;
            O_mem_wren   <= 1'b0;
            O_busy       <= 1'b0;
            O_char_ready <= 1'b1;
          end else begin
            O_mem_addr <= cell_addr(cnt + NW'(1));
            cnt        <= cnt + NW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Directed self-checking bench for text_writer (32x32 screen at 16'h6000).
module tb_text_writer;

  logic        I_clock = 1'b0;
  logic        I_reset;
  logic [7:0]  I_char_data;
  logic        I_char_valid;
  logic        O_char_ready;
  logic [15:0] O_mem_addr;
  logic        O_mem_rden;
  logic        O_mem_wren;
  logic [7:0]  O_mem_data;
  logic [7:0]  I_mem_data = 8'h00;
  logic        O_busy;
  logic [4:0]  O_cursor_col;
  logic [4:0]  O_cursor_row;

  int asserts = 0;
  int fails   = 0;

  logic [7:0]  mem [0:1023];
  int          wr_cnt = 0, rd_cnt = 0, busy_cnt = 0, both_cnt = 0, oob_cnt = 0;
  logic [15:0] last_wr = 16'h0;

  always #5 I_clock = ~I_clock;

  text_writer #(
    .P_addr_bits(16),
    .P_base     (16'h6000),
    .P_cols     (32),
    .P_rows     (32),
    .P_blank    (8'h20)
  ) dut (
    .I_clock      (I_clock),
    .I_reset      (I_reset),
    .I_char_data  (I_char_data),
    .I_char_valid (I_char_valid),
    .O_char_ready (O_char_ready),
    .O_mem_addr   (O_mem_addr),
    .O_mem_rden   (O_mem_rden),
    .O_mem_wren   (O_mem_wren),
    .O_mem_data   (O_mem_data),
    .I_mem_data   (I_mem_data),
    .O_busy       (O_busy),
    .O_cursor_col (O_cursor_col),
    .O_cursor_row (O_cursor_row)
  );

  // Dual-port memory model: registered read, one cycle latency.
  always @(posedge I_clock) begin
    if (O_mem_rden && O_mem_wren) both_cnt++;
    if (O_busy) busy_cnt++;
    if (O_mem_rden) begin
      rd_cnt++;
      if (O_mem_addr >= 16'h6000 && O_mem_addr < 16'h6400) I_mem_data <= mem[O_mem_addr[9:0]];
      else oob_cnt++;
    end
    if (O_mem_wren) begin
      wr_cnt++;
      last_wr = O_mem_addr;
      if (O_mem_addr >= 16'h6000 && O_mem_addr < 16'h6400) mem[O_mem_addr[9:0]] = O_mem_data;
      else oob_cnt++;
    end
  end

  task automatic send(input logic [7:0] c);
    int n = 0;
    @(negedge I_clock);
    I_char_data  = c;
    I_char_valid = 1'b1;
    while (O_char_ready !== 1'b1 && n < 4000) begin
      @(negedge I_clock);
      n++;
    end
    if (n >= 4000) begin
      asserts++; fails++;
      $display("FAIL send_timeout: ready=%b required 1", O_char_ready);
    end
    @(negedge I_clock);
    I_char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((O_char_ready !== 1'b1 || O_busy !== 1'b0) && n < 5000) begin
      @(negedge I_clock);
      n++;
    end
    if (n >= 5000) begin
      asserts++; fails++;
      $display("FAIL idle_timeout: busy=%b ready=%b required 0/1", O_busy, O_char_ready);
    end
  endtask

  task automatic test_reset();
    I_reset = 1'b0; I_char_valid = 1'b0; I_char_data = 8'h00;
    repeat (3) @(negedge I_clock);
    asserts++;
    if ({O_char_ready, O_mem_rden, O_mem_wren, O_busy} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl: rdy/rd/wr/busy=%b required 0000",
                        {O_char_ready, O_mem_rden, O_mem_wren, O_busy});
    end
    asserts++;
    if (O_mem_addr !== 16'h0 || O_mem_data !== 8'h0) begin
      fails++; $display("FAIL reset_bus: addr=%h data=%h required 0000/00", O_mem_addr, O_mem_data);
    end
    asserts++;
    if (O_cursor_col !== 5'd0 || O_cursor_row !== 5'd0) begin
      fails++; $display("FAIL reset_cursor: (%0d,%0d) required (0,0)", O_cursor_col, O_cursor_row);
    end
    I_reset = 1'b1;
    @(negedge I_clock);
    asserts++;
    if (O_char_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: %b required 1", O_char_ready);
    end
  endtask

  task automatic test_put();
    int w0 = wr_cnt;
    send(8'h41);
    asserts++;
    if (O_char_ready !== 1'b0 || O_mem_wren !== 1'b1) begin
      fails++; $display("FAIL put_strobe: ready=%b wren=%b required 0/1", O_char_ready, O_mem_wren);
    end
    asserts++;
    if (O_mem_addr !== 16'h6000 || O_mem_data !== 8'h41) begin
      fails++; $display("FAIL put_bus: addr=%h data=%h required 6000/41", O_mem_addr, O_mem_data);
    end
    @(negedge I_clock);
    asserts++;
    if (O_char_ready !== 1'b1 || O_mem_wren !== 1'b0) begin
      fails++; $display("FAIL put_ready_back: ready=%b wren=%b required 1/0", O_char_ready, O_mem_wren);
    end
    asserts++;
    if (wr_cnt - w0 != 1 || mem[0] !== 8'h41) begin
      fails++; $display("FAIL put_write: writes=%0d cell=%h required 1/41", wr_cnt - w0, mem[0]);
    end
    asserts++;
    if (O_cursor_col !== 5'd1 || O_cursor_row !== 5'd0) begin
      fails++; $display("FAIL put_cursor: (%0d,%0d) required (1,0)", O_cursor_col, O_cursor_row);
    end
  endtask

  task automatic test_row();
    int w0, b0, bad;
    send(8'h0D);
    repeat (5) send(8'h0A);
    w0 = wr_cnt; b0 = busy_cnt;
    repeat (32) send(8'h42);
    @(negedge I_clock);
    asserts++;
    if (last_wr !== 16'h60BF || wr_cnt - w0 != 32) begin
      fails++; $display("FAIL row_writes: last=%h n=%0d required 60bf/32", last_wr, wr_cnt - w0);
    end
    asserts++;
    if (busy_cnt != b0) begin
      fails++; $display("FAIL row_no_scroll: busy cycles=%0d required 0", busy_cnt - b0);
    end
    asserts++;
    if (O_cursor_col !== 5'd0 || O_cursor_row !== 5'd6) begin
      fails++; $display("FAIL row_cursor: (%0d,%0d) required (0,6)", O_cursor_col, O_cursor_row);
    end
    bad = 0;
    for (int i = 160; i < 192; i++) if (mem[i] !== 8'h42) bad++;
    asserts++;
    if (bad != 0) begin
      fails++; $display("FAIL row_content: bad cells=%0d required 0", bad);
    end
  endtask

  task automatic test_clear();
    int w0, b0, n, bad;
    for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
    w0 = wr_cnt; b0 = busy_cnt;
    send(8'h0C);
    I_char_data = 8'h5A; I_char_valid = 1'b1; n = 0;
    while (O_char_ready !== 1'b1 && n < 3000) begin
      @(negedge I_clock);
      n++;
    end
    asserts++;
    if (n != 1024) begin
      fails++; $display("FAIL clear_hold: pending char waited %0d cycles required 1024", n);
    end
    @(negedge I_clock);
    I_char_valid = 1'b0;
    @(negedge I_clock);
    asserts++;
    if (busy_cnt - b0 != 1024 || wr_cnt - w0 != 1025) begin
      fails++; $display("FAIL clear_counts: busy=%0d writes=%0d required 1024/1025",
                        busy_cnt - b0, wr_cnt - w0);
    end
    bad = 0;
    for (int i = 1; i < 1024; i++) if (mem[i] !== 8'h20) bad++;
    asserts++;
    if (bad != 0 || mem[0] !== 8'h5A) begin
      fails++; $display("FAIL clear_content: bad cells=%0d cell0=%h required 0/5a", bad, mem[0]);
    end
    asserts++;
    if (O_cursor_col !== 5'd1 || O_cursor_row !== 5'd0) begin
      fails++; $display("FAIL clear_cursor: (%0d,%0d) required (1,0)", O_cursor_col, O_cursor_row);
    end
  endtask

  task automatic test_scroll();
    int w0, b0, r0, bad;
    logic [7:0] exp;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i / 32);
    send(8'h0D);
    repeat (31) send(8'h0A);
    asserts++;
    if (O_cursor_col !== 5'd0 || O_cursor_row !== 5'd31 || O_busy !== 1'b0) begin
      fails++; $display("FAIL scroll_setup: (%0d,%0d) busy=%b required (0,31) 0",
                        O_cursor_col, O_cursor_row, O_busy);
    end
    w0 = wr_cnt; b0 = busy_cnt; r0 = rd_cnt;
    send(8'h0A);
    wait_idle();
    asserts++;
    if (busy_cnt - b0 != 2016) begin
      fails++; $display("FAIL scroll_busy: cycles=%0d required 2016", busy_cnt - b0);
    end
    asserts++;
    if (wr_cnt - w0 != 1024 || rd_cnt - r0 != 992) begin
      fails++; $display("FAIL scroll_access: writes=%0d reads=%0d required 1024/992",
                        wr_cnt - w0, rd_cnt - r0);
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      exp = (i < 992) ? 8'(i / 32 + 1) : 8'h20;
      if (mem[i] !== exp) bad++;
    end
    asserts++;
    if (bad != 0) begin
      fails++; $display("FAIL scroll_content: bad cells=%0d required 0", bad);
    end
    asserts++;
    if (O_cursor_col !== 5'd0 || O_cursor_row !== 5'd31) begin
      fails++; $display("FAIL scroll_cursor: (%0d,%0d) required (0,31)", O_cursor_col, O_cursor_row);
    end
  endtask

  task automatic test_bs_cr();
    int w0;
    w0 = wr_cnt;
    send(8'h08);
    asserts++;
    if (O_cursor_col !== 5'd0 || O_cursor_row !== 5'd31 || wr_cnt != w0) begin
      fails++; $display("FAIL bs_col0: (%0d,%0d) writes=%0d required (0,31) 0",
                        O_cursor_col, O_cursor_row, wr_cnt - w0);
    end
    repeat (17) send(8'h78);
    @(negedge I_clock);
    w0 = wr_cnt;
    send(8'h08);
    asserts++;
    if (O_cursor_col !== 5'd16) begin
      fails++; $display("FAIL bs_step: col=%0d required 16", O_cursor_col);
    end
    send(8'h0D);
    asserts++;
    if (O_cursor_col !== 5'd0 || O_cursor_row !== 5'd31 || O_char_ready !== 1'b1) begin
      fails++; $display("FAIL cr: (%0d,%0d) ready=%b required (0,31) 1",
                        O_cursor_col, O_cursor_row, O_char_ready);
    end
    send(8'h01);
    asserts++;
    if (O_cursor_col !== 5'd0 || wr_cnt != w0) begin
      fails++; $display("FAIL discard: col=%0d writes=%0d required 0/0", O_cursor_col, wr_cnt - w0);
    end
    repeat (3) send(8'h79);
    @(negedge I_clock);
    w0 = wr_cnt;
    send(8'h09);
    asserts++;
`ifdef TEXT_WRITER_TAB_EN
    if (O_cursor_col !== 5'd8 || wr_cnt != w0) begin
      fails++; $display("FAIL tab: col=%0d writes=%0d required 8/0", O_cursor_col, wr_cnt - w0);
    end
`else
    if (O_cursor_col !== 5'd3 || wr_cnt != w0) begin
      fails++; $display("FAIL tab_discard: col=%0d writes=%0d required 3/0", O_cursor_col, wr_cnt - w0);
    end
`endif
  endtask

  task automatic test_reset_mid_scroll();
    int w0, r0;
    send(8'h0A);
    repeat (100) @(negedge I_clock);
    asserts++;
    if (O_busy !== 1'b1) begin
      fails++; $display("FAIL midscroll_busy: %b required 1", O_busy);
    end
    I_reset = 1'b0;
    #1;
    asserts++;
    if ({O_char_ready, O_mem_rden, O_mem_wren, O_busy} !== 4'b0000 ||
        O_mem_addr !== 16'h0 || O_mem_data !== 8'h0) begin
      fails++; $display("FAIL abort_outputs: rdy/rd/wr/busy=%b addr=%h data=%h required 0000/0000/00",
                        {O_char_ready, O_mem_rden, O_mem_wren, O_busy}, O_mem_addr, O_mem_data);
    end
    w0 = wr_cnt; r0 = rd_cnt;
    repeat (10) @(negedge I_clock);
    asserts++;
    if (wr_cnt != w0 || rd_cnt != r0) begin
      fails++; $display("FAIL abort_quiet: writes=%0d reads=%0d required 0/0", wr_cnt - w0, rd_cnt - r0);
    end
    I_reset = 1'b1;
    @(negedge I_clock);
    asserts++;
    if (O_char_ready !== 1'b1 || O_cursor_col !== 5'd0 || O_cursor_row !== 5'd0) begin
      fails++; $display("FAIL abort_release: ready=%b (%0d,%0d) required 1 (0,0)",
                        O_char_ready, O_cursor_col, O_cursor_row);
    end
  endtask

  // Starts on a negedge with ready already high; valid held for 8 cycles.
  task automatic test_back_to_back();
    int w0 = wr_cnt;
    I_char_data = 8'h43; I_char_valid = 1'b1;
    repeat (8) @(negedge I_clock);
    I_char_valid = 1'b0;
    @(negedge I_clock);
    asserts++;
    if (wr_cnt - w0 != 4 || O_cursor_col !== 5'd4) begin
      fails++; $display("FAIL back_to_back: writes=%0d col=%0d required 4/4", wr_cnt - w0, O_cursor_col);
    end
  endtask

  task automatic test_integrity();
    asserts++;
    if (both_cnt != 0 || oob_cnt != 0) begin
      fails++; $display("FAIL integrity: rd&wr cycles=%0d out-of-range=%0d required 0/0", both_cnt, oob_cnt);
    end
  endtask

  initial begin
    I_reset = 1'b0; I_char_valid = 1'b0; I_char_data = 8'h00;
    test_reset();
    test_put();
    test_row();
    test_clear();
    test_scroll();
    test_bs_cr();
    test_reset_mid_scroll();
    test_back_to_back();
    test_integrity();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
